// File: rtl/bcd_counter.sv
// Multi-digit synchronous BCD up/down counter with a clock-enable prescaler.
// Feeds per-digit seven-segment decoders; every digit stays within 0..9.
module bcd_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int PS_W       = 32
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    step,
    output logic                    wrap,
    output logic                    all_zero
);

    localparam int              DW      = 4 * NUM_DIGITS;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic            step_q, step_d;
    logic            wrap_q, wrap_d;

    logic [DW-1:0]   load_clean;
    logic [DW-1:0]   count_val;
    logic            carry;

    // Invalid load nibbles are forced to 0 so the decoders never see 10..15.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
            end else begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Carry/borrow ripples through all digits in one cycle; the final carry is the wrap.
    always_comb begin
        count_val = digits_q;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    if (digits_q[4*i +: 4] == 4'd9) begin
                        count_val[4*i +: 4] = 4'd0;
                        carry               = 1'b1;
                    end else begin
                        count_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
                        carry               = 1'b0;
                    end
                end else begin
                    if (digits_q[4*i +: 4] == 4'd0) begin
                        count_val[4*i +: 4] = 4'd9;
                        carry               = 1'b1;
                    end else begin
                        count_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
                        carry               = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        ps_d     = ps_q;
        digits_d = digits_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        if (load) begin
            digits_d = load_clean;
            ps_d     = '0;
        end else if (en) begin
            if (ps_q == PS_LAST) begin
                ps_d     = '0;
                digits_d = count_val;
                step_d   = 1'b1;
                wrap_d   = carry;
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ps_q     <= '0;
            digits_q <= '0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            digits_q <= digits_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign digits   = digits_q;
    assign step     = step_q;
    assign wrap     = wrap_q;
    assign all_zero = (digits_q == '0);

endmodule
